// File: rtl/id_issue_queue_if.sv
// -----------------------------------------------------------------------------
// id_issue_queue_if
// Bundles every non-clock signal of the decode issue queue.
//   Fetch side    : in_valid, in_ready, in_pc, in_inst, flush
//   Regfile side  : rf_raddr1/2 (queue drives), rf_rdata1/2 (combinational data)
//   Forward side  : fwd_we, fwd_waddr, fwd_wdata, fwd_is_load (channel 0 youngest)
//   Execute side  : out_valid, out_ready, out_pc, out_inst, out_src1/2, stallreq
//   Status        : count, hazard_cnt
// Modports: slave = the queue itself, master = the surrounding pipeline.
// DEPTH/NUM_FWD must match the parameters of the attached queue.
//
// Handshake: a transfer on in_* happens on a rising edge where in_valid and
// in_ready are both high and flush is low; a transfer on out_* happens on a
// rising edge where out_valid and out_ready are both high and flush is low.
// in_ready never depends on out_ready; out_valid may drop combinationally
// when a load-use hazard appears on the head entry.
// -----------------------------------------------------------------------------
interface id_issue_queue_if #(
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_pc;
  logic [31:0]            in_inst;
  logic                   flush;
  logic [4:0]             rf_raddr1;
  logic [4:0]             rf_raddr2;
  logic [31:0]            rf_rdata1;
  logic [31:0]            rf_rdata2;
  logic [NUM_FWD-1:0]     fwd_we;
  logic [5*NUM_FWD-1:0]   fwd_waddr;
  logic [32*NUM_FWD-1:0]  fwd_wdata;
  logic [NUM_FWD-1:0]     fwd_is_load;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic [31:0]            out_src1;
  logic [31:0]            out_src2;
  logic                   stallreq;
  logic [CW-1:0]          count;
  logic [15:0]            hazard_cnt;

  modport slave (
    input  in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_is_load, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
           out_src1, out_src2, stallreq, count, hazard_cnt
  );

  modport master (
    output in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_is_load, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
           out_src1, out_src2, stallreq, count, hazard_cnt
  );
endinterface

// File: rtl/id_issue_queue.sv
// -----------------------------------------------------------------------------
// id_issue_queue
// First-word-fall-through instruction queue between fetch and execute with
// operand forwarding and a load-use interlock on the head entry.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset (clears pointers, count,
//            hazard counter and storage)
//   bus    - id_issue_queue_if.slave carrying the fetch, regfile, forwarding,
//            execute and status signals
// -----------------------------------------------------------------------------
module id_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 3
) (
  input  logic           clk,
  input  logic           resetn,
  id_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_hazard_cnt;

  logic          w_empty;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_inst;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [31:0]   w_src1;
  logic [31:0]   w_src2;
  logic          w_ld1;
  logic          w_ld2;
  logic          w_hazard;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;

  assign w_empty     = (r_count == '0);
  assign w_head_pc   = w_empty ? 32'd0 : r_pc[r_rptr];
  assign w_head_inst = w_empty ? 32'd0 : r_inst[r_rptr];
  assign w_rs        = w_head_inst[25:21];
  assign w_rt        = w_head_inst[20:16];

  // Scan from the oldest channel to the youngest so the lowest matching index
  // wins; its load flag travels with it, so a younger non-load match hides an
  // older load. Register 0 always reads as zero and never interlocks.
  always_comb begin
    w_src1 = bus.rf_rdata1;
    w_ld1  = 1'b0;
    w_src2 = bus.rf_rdata2;
    w_ld2  = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (bus.fwd_we[k] && (bus.fwd_waddr[5*k +: 5] == w_rs)) begin
        w_src1 = bus.fwd_wdata[32*k +: 32];
        w_ld1  = bus.fwd_is_load[k];
      end
      if (bus.fwd_we[k] && (bus.fwd_waddr[5*k +: 5] == w_rt)) begin
        w_src2 = bus.fwd_wdata[32*k +: 32];
        w_ld2  = bus.fwd_is_load[k];
      end
    end
    if (w_rs == 5'd0) begin
      w_src1 = 32'd0;
      w_ld1  = 1'b0;
    end
    if (w_rt == 5'd0) begin
      w_src2 = 32'd0;
      w_ld2  = 1'b0;
    end
  end

  // Both fields are checked whatever the opcode: a conservative interlock.
  assign w_hazard    = !w_empty && (w_ld1 || w_ld2);
  // Full queue refuses a push even when a pop happens in the same cycle.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = !w_empty && !w_hazard && !bus.flush;
  assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= 32'd0;
        r_inst[i] <= 32'd0;
      end
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wptr]   <= bus.in_pc;
        r_inst[r_wptr] <= bus.in_inst;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stall-cycle statistic survives flushes; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hazard_cnt <= 16'd0;
    end else if (w_hazard && (r_hazard_cnt != 16'hFFFF)) begin
      r_hazard_cnt <= r_hazard_cnt + 16'd1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.rf_raddr1  = w_rs;
  assign bus.rf_raddr2  = w_rt;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_pc     = w_head_pc;
  assign bus.out_inst   = w_head_inst;
  assign bus.out_src1   = w_src1;
  assign bus.out_src2   = w_src2;
  assign bus.stallreq   = w_hazard;
  assign bus.count      = r_count;
  assign bus.hazard_cnt = r_hazard_cnt;
endmodule
